a_demux_serial_1v16: RTL and testbench

Serial-to-parallel receiver for the two-byte RS232 word link. It accepts the 20-bit frame produced by the 16-bit serial transmitter on the same link: two UART characters, each 1 start bit (0), 8 data bits LSB first and 1 stop bit (1), low byte first. It reassembles them into one 16-bit word. The block sits on the receive side of the management communication path and presents a single-cycle data-valid pulse to the host-side logic.

---
 rtl/a_demux_serial_1v16.sv | 212 +++++++++++++++++++++
 tb/tb_a_demux_serial_1v16.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_demux_serial_1v16.sv
`default_nettype none
// ============================================================================
// Module   : a_demux_serial_1v16
// Brief    : Oversampled two-character RS232 receiver that rebuilds a 16-bit
//            word. The optional high-byte timeout is enabled by defining the
//            macro A_DEMUX_RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module a_demux_serial_1v16 #(
    parameter int OVERSAMPLE   = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk_ref,
    input  logic        rst,
    input  logic        clk_sample,
    input  logic        di_i,
    output logic [15:0] r_data_o,
    output logic        r_dv_o,
    output logic        r_busy_o,
    output logic        r_err_o
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);

    localparam logic [c_TICK_W-1:0] c_TICK_HALF = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_GAP   = 3'd4;
    localparam logic [2:0] c_ST_BREAK = 3'd5;

    logic [1:0]          r_sync;
    logic                w_s_di;
    logic [2:0]          r_state;
    logic [c_TICK_W-1:0] r_tick;
    logic [2:0]          r_bit;
    logic                r_byte;
    logic [7:0]          r_shift;
    logic [7:0]          r_low;

    logic [2:0]          w_state_nxt;
    logic [c_TICK_W-1:0] w_tick_nxt;
    logic [c_TICK_W-1:0] w_tick_inc;
    logic                w_tick_mid;
    logic                w_tick_end;
    logic [2:0]          w_bit_nxt;
    logic                w_byte_nxt;
    logic [7:0]          w_shift_nxt;
    logic [7:0]          w_low_nxt;
    logic                w_busy_nxt;
    logic                w_dv;
    logic                w_err;

`ifdef A_DEMUX_RX_TIMEOUT_EN
    localparam int c_GAP_W = $clog2(TIMEOUT_BITS * OVERSAMPLE);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(TIMEOUT_BITS * OVERSAMPLE - 1);

    logic [c_GAP_W-1:0] r_gap;
    logic [c_GAP_W-1:0] w_gap_nxt;
`else
    // TIMEOUT_BITS has no effect while the high-byte wait is unbounded.
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_BITS);
`endif

    assign w_s_di     = r_sync[1];
    assign w_tick_mid = (r_tick == c_TICK_HALF);
    assign w_tick_end = (r_tick == c_TICK_LAST);
    assign w_tick_inc = w_tick_end ? '0 : r_tick + c_TICK_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_shift_nxt = r_shift;
        w_low_nxt   = r_low;
        w_busy_nxt  = r_busy_o;
        w_dv        = 1'b0;
        w_err       = 1'b0;
`ifdef A_DEMUX_RX_TIMEOUT_EN
        w_gap_nxt   = r_gap;
`endif
        if (clk_sample) begin
            case (r_state)
                c_ST_IDLE: begin
                    w_tick_nxt = '0;
                    if (!w_s_di) begin
                        w_state_nxt = c_ST_START;
                        w_byte_nxt  = 1'b0;
                        w_busy_nxt  = 1'b1;
                    end
                end
                c_ST_START: begin
                    if (w_tick_mid) begin
                        w_tick_nxt = '0;
                        w_bit_nxt  = '0;
                        if (w_s_di) begin
                            // Line back high at mid start bit: a glitch, not a frame.
                            w_state_nxt = c_ST_IDLE;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = c_ST_DATA;
                        end
                    end else begin
                        w_tick_nxt = w_tick_inc;
                    end
                end
                c_ST_DATA: begin
                    w_tick_nxt = w_tick_inc;
                    if (w_tick_end) begin
                        w_shift_nxt = {w_s_di, r_shift[7:1]};
                        w_bit_nxt   = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            w_state_nxt = c_ST_STOP;
                        end
                    end
                end
                c_ST_STOP: begin
                    w_tick_nxt = w_tick_inc;
                    if (w_tick_end) begin
                        w_tick_nxt = '0;
                        if (!w_s_di) begin
                            w_err       = 1'b1;
                            w_state_nxt = c_ST_BREAK;
                        end else if (!r_byte) begin
                            w_low_nxt   = r_shift;
                            w_state_nxt = c_ST_GAP;
`ifdef A_DEMUX_RX_TIMEOUT_EN
                            w_gap_nxt   = '0;
`endif
                        end else begin
                            w_dv        = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = c_ST_IDLE;
                        end
                    end
                end
                c_ST_GAP: begin
                    w_tick_nxt = '0;
                    if (!w_s_di) begin
                        w_state_nxt = c_ST_START;
                        w_byte_nxt  = 1'b1;
                    end
`ifdef A_DEMUX_RX_TIMEOUT_EN
                    else if (r_gap == c_GAP_LAST) begin
                        w_err       = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_low_nxt   = '0;
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_gap_nxt = r_gap + c_GAP_W'(1);
                    end
`endif
                end
                c_ST_BREAK: begin
                    w_tick_nxt = '0;
                    if (w_s_di) begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
                default: begin
                    w_tick_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_state  <= c_ST_IDLE;
            r_tick   <= '0;
            r_bit    <= '0;
            r_byte   <= 1'b0;
            r_shift  <= '0;
            r_low    <= '0;
            r_data_o <= 16'h0000;
            r_dv_o   <= 1'b0;
            r_busy_o <= 1'b0;
            r_err_o  <= 1'b0;
`ifdef A_DEMUX_RX_TIMEOUT_EN
            r_gap    <= '0;
`endif
        end else begin
            r_sync   <= {r_sync[0], di_i};
            r_state  <= w_state_nxt;
            r_tick   <= w_tick_nxt;
            r_bit    <= w_bit_nxt;
            r_byte   <= w_byte_nxt;
            r_shift  <= w_shift_nxt;
            r_low    <= w_low_nxt;
            r_dv_o   <= w_dv;
            r_busy_o <= w_busy_nxt;
            r_err_o  <= w_err;
            if (w_dv) begin
                r_data_o <= {r_shift, r_low};
            end
`ifdef A_DEMUX_RX_TIMEOUT_EN
            r_gap    <= w_gap_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_a_demux_serial_1v16.sv
`default_nettype none
// ============================================================================
// Module   : tb_a_demux_serial_1v16
// Brief    : Self-checking bench for the 16-bit two-character serial receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a_demux_serial_1v16;

    localparam int OS         = 16;
    localparam int TO_BITS    = 20;
    localparam int STROBE_DIV = 3;

    typedef struct {
        logic [15:0] word;
        bit          lo_ok;
        bit          hi_ok;
        int          gap;
        int          exp_dv;
        int          exp_err;
    } vec_t;

    logic        clk_ref = 1'b0;
    logic        rst;
    logic        clk_sample;
    logic        di_i;
    logic [15:0] r_data_o;
    logic        r_dv_o;
    logic        r_busy_o;
    logic        r_err_o;

    a_demux_serial_1v16 #(
        .OVERSAMPLE   (OS),
        .TIMEOUT_BITS (TO_BITS)
    ) u_dut (
        .clk_ref    (clk_ref),
        .rst        (rst),
        .clk_sample (clk_sample),
        .di_i       (di_i),
        .r_data_o   (r_data_o),
        .r_dv_o     (r_dv_o),
        .r_busy_o   (r_busy_o),
        .r_err_o    (r_err_o)
    );

    always #5 clk_ref = ~clk_ref;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          dv_cnt   = 0;
    int          err_cnt  = 0;
    bit          busy_seen = 1'b0;
    logic        dv_prev   = 1'b0;
    logic        err_prev  = 1'b0;
    logic        busy_prev = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] model_data = 16'h0000;
    vec_t        vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    initial begin
        clk_sample = 1'b0;
        forever begin
            for (int k = 0; k < STROBE_DIV; k++) begin
                @(negedge clk_ref);
                clk_sample = (k == 0);
            end
        end
    end

    // Output monitor: every dv pulse must match the next word the model expects.
    always @(negedge clk_ref) begin
        if (!rst) begin
            if (r_dv_o) begin
                dv_cnt++;
                check("dv_single_cycle", 32'(dv_prev), 0);
                check("busy_low_at_dv", 32'(r_busy_o), 0);
                check("busy_high_before_dv", 32'(busy_prev), 1);
                check("dv_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("dv_data", 32'(r_data_o), 32'(exp_q.pop_front()));
            end
            if (r_err_o) begin
                err_cnt++;
                check("err_single_cycle", 32'(err_prev), 0);
            end
            if (r_busy_o) busy_seen = 1'b1;
        end
        dv_prev   = r_dv_o;
        err_prev  = r_err_o;
        busy_prev = r_busy_o;
    end

    task automatic wait_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk_ref); while (clk_sample !== 1'b1);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_ref);
        di_i = b;
        wait_strobes(OS);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_char(input logic [7:0] b, input bit stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
    endtask

    task automatic send_word(input logic [15:0] w, input bit lo_ok, input bit hi_ok, input int gap);
        if (lo_ok && hi_ok) begin
            exp_q.push_back(w);
            model_data = w;
        end
        send_char(w[7:0], lo_ok);
        if (lo_ok) begin
            idle_bits(gap);
            send_char(w[15:8], hi_ok);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int dv0;
        int er0;
        dv0 = dv_cnt;
        er0 = err_cnt;
        send_word(v.word, v.lo_ok, v.hi_ok, v.gap);
        idle_bits(2);
        check({tag, "_dv_count"}, 32'(dv_cnt - dv0), 32'(v.exp_dv));
        check({tag, "_err_count"}, 32'(err_cnt - er0), 32'(v.exp_err));
        check({tag, "_data"}, 32'(r_data_o), 32'(model_data));
        check({tag, "_busy_idle"}, 32'(r_busy_o), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk_ref);
        di_i = 1'b1;
        rst  = 1'b1;
        @(negedge clk_ref);
        rst  = 1'b0;
        exp_q.delete();
        model_data = 16'h0000;
    endtask

    initial begin
        int   dv0;
        int   er0;
        int   wait_cnt;
        bit   lo_ok;
        bit   hi_ok;
        vec_t rv;

        vecs[0] = '{16'hA55A, 1'b1, 1'b1, 0, 1, 0};
        vecs[1] = '{16'h00FF, 1'b1, 1'b1, 2, 1, 0};
        vecs[2] = '{16'h8001, 1'b1, 1'b0, 1, 0, 1};
        vecs[3] = '{16'h005A, 1'b0, 1'b1, 0, 0, 1};
        vecs[4] = '{16'h0000, 1'b1, 1'b1, 5, 1, 0};

        rst  = 1'b1;
        di_i = 1'b1;
        repeat (5) @(negedge clk_ref);
        check("reset_data", 32'(r_data_o), 0);
        check("reset_dv", 32'(r_dv_o), 0);
        check("reset_busy", 32'(r_busy_o), 0);
        check("reset_err", 32'(r_err_o), 0);
        rst = 1'b0;
        idle_bits(1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back words with no idle between frames
        dv0 = dv_cnt;
        send_word(16'h1234, 1'b1, 1'b1, 0);
        send_word(16'hFFFF, 1'b1, 1'b1, 0);
        idle_bits(2);
        check("b2b_dv_count", 32'(dv_cnt - dv0), 2);
        check("b2b_data", 32'(r_data_o), 32'h0000FFFF);
        check("b2b_queue_drained", 32'(exp_q.size()), 0);

        // Start glitch: three low strobes then high
        dv0 = dv_cnt;
        er0 = err_cnt;
        busy_seen = 1'b0;
        @(negedge clk_ref);
        di_i = 1'b0;
        wait_strobes(3);
        @(negedge clk_ref);
        di_i = 1'b1;
        idle_bits(2);
        check("glitch_busy_seen", 32'(busy_seen), 1);
        check("glitch_busy_idle", 32'(r_busy_o), 0);
        check("glitch_dv", 32'(dv_cnt - dv0), 0);
        check("glitch_err", 32'(err_cnt - er0), 0);

        // Framing error on the low byte; busy held while the line stays low
        dv0 = dv_cnt;
        er0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b1 : 1'b0 ^ ((8'h5A >> i) & 1) ? 1'b1 : 1'b0);
        @(negedge clk_ref);
        di_i = 1'b0;
        wait_cnt = 0;
        while (r_err_o !== 1'b1 && wait_cnt < 2 * OS * STROBE_DIV) begin
            @(negedge clk_ref);
            wait_cnt++;
        end
        check("frame_err_seen", 32'(r_err_o), 1);
        check("frame_err_busy_held", 32'(r_busy_o), 1);
        wait_strobes(OS);
        idle_bits(2);
        check("frame_err_count", 32'(err_cnt - er0), 1);
        check("frame_err_dv", 32'(dv_cnt - dv0), 0);
        check("frame_err_data", 32'(r_data_o), 32'(model_data));
        check("frame_err_busy_idle", 32'(r_busy_o), 0);

        for (int i = 0; i < 12; i++) begin
            lo_ok = ($urandom_range(0, 5) != 0);
            hi_ok = ($urandom_range(0, 5) != 0);
            rv.word    = 16'($urandom);
            rv.lo_ok   = lo_ok;
            rv.hi_ok   = hi_ok;
            rv.gap     = int'($urandom_range(0, 3));
            rv.exp_dv  = (lo_ok && hi_ok) ? 1 : 0;
            rv.exp_err = (lo_ok && hi_ok) ? 0 : 1;
            run_vec(rv, $sformatf("rand%0d", i));
        end

        // Only the low byte, then a long idle line
        er0 = err_cnt;
        send_char(8'h3C, 1'b1);
        idle_bits(19);
        check("timeout_not_early", 32'(err_cnt - er0), 0);
        idle_bits(2);
`ifdef A_DEMUX_RX_TIMEOUT_EN
        check("timeout_err", 32'(err_cnt - er0), 1);
        check("timeout_busy", 32'(r_busy_o), 0);
`else
        check("no_timeout_err", 32'(err_cnt - er0), 0);
        check("no_timeout_busy", 32'(r_busy_o), 1);
`endif
        pulse_reset();
        check("post_timeout_reset_busy", 32'(r_busy_o), 0);

        // Reset in the middle of the high byte of 16'hBEEF
        dv0 = dv_cnt;
        er0 = err_cnt;
        send_char(8'hEF, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        pulse_reset();
        check("midrst_data", 32'(r_data_o), 0);
        check("midrst_dv", 32'(r_dv_o), 0);
        check("midrst_busy", 32'(r_busy_o), 0);
        check("midrst_err", 32'(r_err_o), 0);
        idle_bits(2);
        check("midrst_no_dv", 32'(dv_cnt - dv0), 0);
        check("midrst_no_err", 32'(err_cnt - er0), 0);
        rv = '{16'h0001, 1'b1, 1'b1, 0, 1, 0};
        run_vec(rv, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
